// File: rtl/rtc_lectura_captura_pkg.sv
// Shared encodings for the RTC time-of-day scanner: FSM states, register map, BCD limits.
package rtc_lectura_captura_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] ADDR_SEG  = 8'h02;
    localparam logic [7:0] ADDR_MIN  = 8'h03;
    localparam logic [7:0] ADDR_HORA = 8'h04;

    localparam logic [7:0] LIM_MIN_SEG = 8'h59;
    localparam logic [7:0] LIM_HORA    = 8'h23;

    localparam int TIMEOUT_CYC_DEF = 63;

    function automatic logic [7:0] addr_of(input logic [1:0] idx);
        logic [7:0] a;
        case (idx)
            2'd0:    a = ADDR_SEG;
            2'd1:    a = ADDR_MIN;
            default: a = ADDR_HORA;
        endcase
        return a;
    endfunction

    function automatic logic [7:0] limit_of(input logic [1:0] idx);
        return (idx == 2'd2) ? LIM_HORA : LIM_MIN_SEG;
    endfunction

endpackage

// File: rtl/rtc_bcd_check.sv
// Combinational BCD sanity check: both nibbles decimal and value within the field limit.
// Zero latency, no flow control.
module rtc_bcd_check (
    input  logic [7:0] value,
    input  logic [7:0] limit,
    output logic       ok
);

    assign ok = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= limit);

endmodule

// File: rtl/rtc_lectura_captura.sv
// Scans RTC seconds/minutes/hours via a read-cycle stage, validating BCD before capture.
// Min 13 cycles start-to-scan_done; waits on rd_done edges, bounded by TIMEOUT_CYC per read.
module rtc_lectura_captura
    import rtc_lectura_captura_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       resetcounterl,
    input  logic       start,
    input  logic       rd_valid,
    input  logic [7:0] rd_data,
    input  logic       rd_done,
    output logic       rd_start,
    output logic [7:0] rd_addr,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic       busy,
    output logic       scan_done,
    output logic       bcd_err,
    output logic       timeout
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_idx;
    logic [7:0]      r_data_q;
    logic [7:0]      r_rd_addr;
    logic [7:0]      r_seg;
    logic [7:0]      r_min;
    logic [7:0]      r_hora;
    logic            r_bcd_err;
    logic            r_timeout;
    logic            r_done_q;
    logic [CW-1:0]   r_wait_cnt;
    logic            w_done_rise;
    logic            w_wait_last;
    logic            w_ok;

    // A done level left high by the previous transaction must not count as completion.
    assign w_done_rise = rd_done && !r_done_q;
    assign w_wait_last = (r_wait_cnt == CW'(TIMEOUT_CYC - 1));

    rtc_bcd_check u_bcd (
        .value (r_data_q),
        .limit (limit_of(r_idx)),
        .ok    (w_ok)
    );

    always_ff @(posedge clk or negedge resetcounterl) begin
        if (!resetcounterl) r_state <= ST_IDLE;
        else                r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_REQ;
            ST_REQ:   w_next = ST_WAIT;
            ST_WAIT: begin
                if (w_done_rise)      w_next = ST_CHECK;
                else if (w_wait_last) w_next = ST_IDLE;
            end
            ST_CHECK: w_next = ST_NEXT;
            ST_NEXT:  w_next = (r_idx == 2'd2) ? ST_DONE : ST_REQ;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetcounterl) begin
        if (!resetcounterl) begin
            r_idx      <= 2'd0;
            r_data_q   <= 8'h00;
            r_rd_addr  <= 8'h00;
            r_seg      <= 8'h00;
            r_min      <= 8'h00;
            r_hora     <= 8'h00;
            r_bcd_err  <= 1'b0;
            r_timeout  <= 1'b0;
            r_done_q   <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_done_q <= rd_done;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx     <= 2'd0;
                        r_bcd_err <= 1'b0;
                        r_timeout <= 1'b0;
                        r_rd_addr <= addr_of(2'd0);
                    end
                end
                ST_REQ: r_wait_cnt <= '0;
                ST_WAIT: begin
                    if (rd_valid) r_data_q <= rd_data;
                    if (!w_done_rise) begin
                        if (w_wait_last) r_timeout  <= 1'b1;
                        else             r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_ok) begin
                        case (r_idx)
                            2'd0:    r_seg  <= r_data_q;
                            2'd1:    r_min  <= r_data_q;
                            default: r_hora <= r_data_q;
                        endcase
                    end else begin
                        r_bcd_err <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (r_idx != 2'd2) begin
                        r_idx     <= r_idx + 2'd1;
                        r_rd_addr <= addr_of(r_idx + 2'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_start  = (r_state == ST_REQ);
    assign busy      = (r_state != ST_IDLE);
    assign scan_done = (r_state == ST_DONE);
    assign rd_addr   = r_rd_addr;
    assign seg       = r_seg;
    assign min       = r_min;
    assign hora      = r_hora;
    assign bcd_err   = r_bcd_err;
    assign timeout   = r_timeout;

endmodule

// File: doc/rtc_lectura_captura.md
RTC_LECTURA_CAPTURA -- requirements
Module: rtc_lectura_captura

Interface
REQ-001 SHALL have port clk  input  1  rising-edge system clock.
REQ-002 SHALL have port resetcounterl  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port start  input  1  level, sampled only in IDLE; requests one time-of-day scan.
REQ-004 SHALL have port rd_valid  input  1  high while the read-cycle stage presents valid data.
REQ-005 SHALL have port rd_data  input  8  data byte from the read-cycle stage (bit 7 = h ... bit 0 = a).
REQ-006 SHALL have port rd_done  input  1  read-cycle stage done flag, level, may stay high.
REQ-007 SHALL have port rd_start  output  1  one-cycle pulse launching one read transaction.
REQ-008 SHALL have port rd_addr  output  8  RTC register address for the current transaction.
REQ-009 SHALL have ports seg, min, hora  output  8 each  last valid BCD seconds/minutes/hours.
REQ-010 SHALL have ports busy, scan_done, bcd_err, timeout  output  1 each  status.
REQ-011 SHALL have parameter TIMEOUT_CYC, default 63, maximum WAIT cycles per transaction.

Function
REQ-012 SHALL implement states IDLE, REQ, WAIT, CHECK, NEXT, DONE, with 2-bit index idx over {seconds, minutes, hours}.
REQ-013 SHALL, in IDLE with start=1, clear bcd_err, timeout and idx, and go to REQ next cycle; busy=1 in every state except IDLE.
REQ-014 SHALL, in REQ, assert rd_start for exactly one cycle, drive rd_addr = 0x02/0x03/0x04 for idx 0/1/2, clear the WAIT counter, and go to WAIT.
REQ-015 SHALL hold rd_addr stable from REQ until the transaction leaves CHECK.
REQ-016 SHALL, in WAIT, load data_q <= rd_data on every cycle with rd_valid=1; the last valid byte wins.
REQ-017 SHALL detect a rd_done rising edge (rd_done=1, registered previous value=0); rd_done held high from an earlier transaction SHALL NOT count.
REQ-018 SHALL, when rd_valid and the rd_done edge coincide, capture that byte and use it in CHECK.
REQ-019 SHALL, on a rd_done edge in WAIT, go to CHECK next cycle.
REQ-020 SHALL, if WAIT lasts TIMEOUT_CYC cycles without an edge, set timeout, go to IDLE, and not assert scan_done; seg/min/hora keep prior values.
REQ-021 SHALL, in CHECK, validate data_q: both nibbles <=9, and value <=0x59 (seconds/minutes) or <=0x23 (hours).
REQ-022 SHALL, if data_q is valid, write it to the register selected by idx; otherwise keep the register and set bcd_err (sticky until next start).
REQ-023 SHALL, in NEXT, go to DONE if idx=2; otherwise increment idx and go to REQ.
REQ-024 SHALL, in DONE, pulse scan_done for one cycle and return to IDLE.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL give minimum scan latency from the start sample to scan_done of 3x(REQ+WAIT+CHECK+NEXT)+1 cycles, where WAIT >= 1 cycle.

Reset
REQ-027 SHALL, while resetcounterl=0, force state IDLE, idx=0, data_q=0, rd_addr=0x00, seg=min=hora=0x00, and rd_start, busy, scan_done, bcd_err, timeout=0.
REQ-028 SHALL, on reset mid-scan, abort without a scan_done pulse and require a new start afterwards.

Structure
REQ-029 SHALL place in the shared package: state encoding, RTC addresses 0x02/0x03/0x04, limits 0x59/0x23, and the TIMEOUT_CYC default.
REQ-030 SHALL put BCD validation in a combinational sub-module rtc_bcd_check (inputs: value, limit; output: ok).

Verification
REQ-031 SHALL cover nominal scan: start=1; stage returns 0x45, 0x30, 0x12 -> three rd_start pulses with rd_addr 0x02, 0x03, 0x04; seg=0x45, min=0x30, hora=0x12; one scan_done pulse; bcd_err=0.
REQ-032 SHALL cover invalid BCD: minutes byte 0x6A with prior min=0x30 -> min stays 0x30, bcd_err=1, scan completes with scan_done.
REQ-033 SHALL cover timeout: no rd_done edge for 63 WAIT cycles on the hours read -> timeout=1, IDLE, no scan_done, hora unchanged.
REQ-034 SHALL cover a stale done level: rd_done held high across REQ -> no CHECK until rd_done falls and rises again.
REQ-035 SHALL cover coincident rd_valid and edge: rd_valid and rd_done edge in the same cycle with 0x59 -> seg=0x59.
REQ-036 SHALL cover mid-scan reset and ignored start: resetcounterl low in WAIT -> all outputs 0; start pulses while busy=1 -> no additional rd_start.
